// File: rtl/gf16_pkg.sv
// GF(2^4) field constants, types and reference functions
// shared by the composite-field AES S-box blocks.
package gf16_pkg;

  localparam logic [4:0] POLY   = 5'h13;
  localparam logic [3:0] LAMBDA = 4'hC;

  typedef logic [3:0] gf16_t;

  typedef enum logic [1:0] {
    GF_MUL,
    GF_SQ,
    GF_SQSC,
    GF_INV
  } gf_op_e;

  function automatic gf16_t gf16_mul(gf16_t a, gf16_t b);
    gf16_t r;
    gf16_t x;
    r = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? POLY[3:0] : 4'h0);
    end
    return r;
  endfunction

  // Squaring is GF(2)-linear: spread bits, then fold x^4 and x^6.
  function automatic gf16_t gf16_sq(gf16_t h);
    return {h[3], h[1] ^ h[3], h[2], h[0] ^ h[2]};
  endfunction

  function automatic gf16_t gf16_inv(gf16_t h);
    gf16_t r;
    unique case (h)
      4'h0: r = 4'h0;
      4'h1: r = 4'h1;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'hD;
      4'h5: r = 4'hB;
      4'h6: r = 4'h7;
      4'h7: r = 4'h6;
      4'h8: r = 4'hF;
      4'h9: r = 4'h2;
      4'hA: r = 4'hC;
      4'hB: r = 4'h5;
      4'hC: r = 4'hA;
      4'hD: r = 4'h4;
      4'hE: r = 4'h3;
      default: r = 4'h8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gf16_mul_comb.sv
// Combinational GF(2^4) multiplier: carry-less
// partial products folded with x^4 = x + 1.
module gf16_mul_comb
  import gf16_pkg::*;
(
  input  gf16_t a_i,
  input  gf16_t b_i,
  output gf16_t p_o
);

  logic [6:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_i[i]) pp = pp ^ ({3'b000, a_i} << i);
    end
  end

  assign p_o = pp[3:0]
             ^ {2'b00, pp[4], pp[4]}
             ^ {1'b0, pp[5], pp[5], 1'b0}
             ^ {pp[6], pp[6], 2'b00};

endmodule

// File: rtl/spem.sv
// Registered GF(2^4) element: multiply, square,
// LAMBDA-scaled square and inverse with 1-cycle latency.
module spem
  import gf16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] op,
  input  logic [3:0] H,
  input  logic [3:0] B,
  output logic [3:0] prod,
  output logic       out_valid
);

  gf_op_e op_e;
  gf16_t  h_sq;
  gf16_t  mul_a;
  gf16_t  mul_b;
  gf16_t  mul_p;
  gf16_t  res;
  gf16_t  prod_d, prod_q;
  logic   vld_q;

  assign op_e = gf_op_e'(op);
  assign h_sq = gf16_sq(H);

  // One multiplier serves both H*B and LAMBDA*H^2.
  assign mul_a = (op_e == GF_SQSC) ? LAMBDA : H;
  assign mul_b = (op_e == GF_SQSC) ? h_sq : B;

  gf16_mul_comb u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    res = '0;
    unique case (op_e)
      GF_MUL:  res = mul_p;
      GF_SQ:   res = h_sq;
      GF_SQSC: res = mul_p;
      GF_INV:  res = gf16_inv(H);
      default: res = '0;
    endcase
  end

  assign prod_d = in_valid ? res : prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= in_valid;
    end
  end

  assign prod      = prod_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_spem.sv
// Self-checking bench for spem: vector table plus
// scoreboard queue of expected results.
module tb_spem;
  import gf16_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [3:0] H;
  logic [3:0] B;
  logic [3:0] prod;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  logic [3:0] sbq[$];
  logic [3:0] last_prod;

  typedef struct {
    logic [1:0] op;
    logic [3:0] h;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[12];

  spem dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .H         (H),
    .B         (B),
    .prod      (prod),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_mul(logic [3:0] a, logic [3:0] b);
    logic [3:0] r;
    logic [3:0] x;
    r = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_inv(logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int y = 1; y < 16; y++) begin
      if (ref_mul(a, 4'(y)) == 4'h1) r = 4'(y);
    end
    return r;
  endfunction

  function automatic logic [3:0] model(logic [1:0] o, logic [3:0] h,
                                       logic [3:0] b);
    logic [3:0] r;
    case (o)
      2'd0:    r = ref_mul(h, b);
      2'd1:    r = ref_mul(h, h);
      2'd2:    r = ref_mul(4'hC, ref_mul(h, h));
      default: r = ref_inv(h);
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step_x(input logic v, input logic [1:0] o,
                        input logic [3:0] h, input logic [3:0] b,
                        input logic [3:0] e);
    logic [3:0] exp;
    @(negedge clk);
    in_valid = v;
    op = o;
    H = h;
    B = b;
    if (v) sbq.push_back(e);
    @(posedge clk);
    #1;
    chk("out_valid", {3'b000, out_valid}, {3'b000, v});
    if (out_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: result with empty queue, got %h", prod);
      end else begin
        exp = sbq.pop_front();
        chk($sformatf("op%0d H=%h B=%h", o, h, b), prod, exp);
        last_prod = exp;
      end
    end else begin
      chk("hold", prod, last_prod);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] o,
                      input logic [3:0] h, input logic [3:0] b);
    step_x(v, o, h, b, model(o, h, b));
  endtask

  logic [3:0] first;
  logic [3:0] inv_r;

  initial begin
    tbl[0]  = '{2'd0, 4'h2, 4'h2, 4'h4};
    tbl[1]  = '{2'd0, 4'h8, 4'h2, 4'h3};
    tbl[2]  = '{2'd0, 4'hF, 4'hF, 4'hA};
    tbl[3]  = '{2'd0, 4'h2, 4'h9, 4'h1};
    tbl[4]  = '{2'd0, 4'h0, 4'h7, 4'h0};
    tbl[5]  = '{2'd0, 4'h1, 4'hB, 4'hB};
    tbl[6]  = '{2'd1, 4'hF, 4'h5, 4'hA};
    tbl[7]  = '{2'd2, 4'h1, 4'h3, 4'hC};
    tbl[8]  = '{2'd3, 4'h2, 4'h7, 4'h9};
    tbl[9]  = '{2'd3, 4'h0, 4'h1, 4'h0};
    tbl[10] = '{2'd1, 4'h2, 4'hE, 4'h4};
    tbl[11] = '{2'd2, 4'h2, 4'h0, 4'h5};

    rst = 1'b1;
    in_valid = 1'b0;
    op = 2'd0;
    H = 4'h0;
    B = 4'h0;
    last_prod = 4'h0;
    #1;
    chk("reset prod", prod, 4'h0);
    chk("reset valid", {3'b000, out_valid}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, back-to-back.
    foreach (tbl[i]) step_x(1'b1, tbl[i].op, tbl[i].h, tbl[i].b, tbl[i].exp);

    // Idle for 3 cycles: prod must hold.
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 4'h7, 4'h7);

    // Exhaustive multiply with swapped repeat.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(1'b1, 2'd0, 4'(a), 4'(b));
        first = prod;
        step(1'b1, 2'd0, 4'(b), 4'(a));
        chk("commute", prod, first);
      end
    end

    // Square and scaled square sweeps.
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 2'd1, 4'(a), 4'($urandom_range(0, 15)));
      step(1'b1, 2'd2, 4'(a), 4'($urandom_range(0, 15)));
    end

    // Inverse fed back through multiply must give 1.
    for (int a = 1; a < 16; a++) begin
      step(1'b1, 2'd3, 4'(a), 4'h0);
      inv_r = prod;
      step_x(1'b1, 2'd0, 4'(a), inv_r, 4'h1);
    end
    step(1'b1, 2'd3, 4'h0, 4'h0);

    // Async reset mid-cycle with a result pending.
    step(1'b1, 2'd0, 4'hF, 4'hF);
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'd0;
    H = 4'h3;
    B = 4'h3;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst prod", prod, 4'h0);
    chk("async rst valid", {3'b000, out_valid}, 4'h0);
    @(posedge clk);
    #1;
    chk("rst hold prod", prod, 4'h0);
    chk("rst hold valid", {3'b000, out_valid}, 4'h0);
    sbq.delete();
    last_prod = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd0, 4'h2, 4'h2);
    step(1'b1, 2'd0, 4'h8, 4'h2);
    step(1'b0, 2'd0, 4'h0, 4'h0);

    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results left, want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
